// File: rtl/hdmi_period_scheduler.sv
// Schedules control / video-preamble / guard-band / video periods ahead of the three TMDS encoders.
// Latency: sync, active and pixel inputs reach the outputs PREAMBLE_LEN+GUARD_LEN+1 (11) cycles later.
// Backpressure: none; free-running pixel stream, one pixel accepted and one emitted every cycle.
module hdmi_period_scheduler #(
  parameter int HDMI_MODE    = 1,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       hsyncIn,
  input  logic       vsyncIn,
  input  logic       activeIn,
  input  logic [7:0] redIn,
  input  logic [7:0] greenIn,
  input  logic [7:0] blueIn,
  input  logic       errClear,
  output logic       de,
  output logic [1:0] ctl0,
  output logic [1:0] ctl1,
  output logic [1:0] ctl2,
  output logic       guardBand,
  output logic [7:0] redOut,
  output logic [7:0] greenOut,
  output logic [7:0] blueOut,
  output logic [1:0] hdmiState,
  output logic       shortBlankErr
);

  // The delay line gives the FSM a view of activeIn LOOKAHEAD cycles before
  // the matching pixel reaches the output, which is exactly the preamble+guard span.
  localparam int LOOKAHEAD  = PREAMBLE_LEN + GUARD_LEN;
  // Extra margin so a full preamble never overlaps the tail of the previous line.
  localparam int QUAL_BLANK = LOOKAHEAD + 4;
  localparam int PHASE_W    = $clog2(LOOKAHEAD + 1);

  typedef enum logic [1:0] {
    CTRL  = 2'd0,
    PRE   = 2'd1,
    GUARD = 2'd2,
    VIDEO = 2'd3
  } state_t;

  typedef struct packed {
    logic       vsync;
    logic       hsync;
    logic       active;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } lane_t;

  lane_t               laneIn;
  lane_t               laneDly;
  lane_t               delayLine [LOOKAHEAD];
  logic [3:0]          blankCnt;
  logic                riseEdge;
  logic                qualified;
  logic                shortSet;
  state_t              state;
  state_t              stateNext;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  phaseNext;
  logic                deNext;
  logic                guardNext;
  logic [1:0]          ctl1Next;
  logic [1:0]          ctl2Next;
  logic [23:0]         pixelNext;

  assign laneIn = '{vsync: vsyncIn, hsync: hsyncIn, active: activeIn,
                    red: redIn, green: greenIn, blue: blueIn};
  assign laneDly = delayLine[LOOKAHEAD-1];

  // Shift every input through the lookahead delay line.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < LOOKAHEAD; i++) delayLine[i] <= '0;
    end else begin
      delayLine[0] <= laneIn;
      for (int i = 1; i < LOOKAHEAD; i++) delayLine[i] <= delayLine[i-1];
    end
  end

  // Count consecutive blank input cycles; reset value 15 makes the first line after reset qualify.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      blankCnt <= 4'hF;
    end else if (activeIn) begin
      blankCnt <= 4'h0;
    end else if (blankCnt != 4'hF) begin
      blankCnt <= blankCnt + 4'h1;
    end
  end

  // A nonzero blank count means the previous input cycle was blank, so activeIn now is a rising edge.
  assign riseEdge  = activeIn && (blankCnt != 4'h0);
  assign qualified = (HDMI_MODE != 0) && riseEdge && (32'(blankCnt) >= QUAL_BLANK);
  assign shortSet  = (HDMI_MODE != 0) && riseEdge && !qualified;

  // Sticky short-blanking flag; a new violation in the same cycle beats errClear.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      shortBlankErr <= 1'b0;
    end else if (shortSet) begin
      shortBlankErr <= 1'b1;
    end else if (errClear) begin
      shortBlankErr <= 1'b0;
    end
  end

  // State register with the PRE/GUARD phase counter.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state <= CTRL;
      phase <= '0;
    end else begin
      state <= stateNext;
      phase <= phaseNext;
    end
  end

  // Next-state logic: a qualified edge starts the preamble, which runs to completion regardless of activeIn.
  always_comb begin
    stateNext = state;
    phaseNext = phase;
    case (state)
      CTRL: begin
        if (laneDly.active) begin
          stateNext = VIDEO;
        end else if (qualified) begin
          stateNext = PRE;
          phaseNext = '0;
        end
      end
      PRE: begin
        if (phase == PHASE_W'(PREAMBLE_LEN - 1)) begin
          stateNext = GUARD;
          phaseNext = '0;
        end else begin
          phaseNext = phase + PHASE_W'(1);
        end
      end
      GUARD: begin
        if (phase == PHASE_W'(GUARD_LEN - 1)) begin
          stateNext = VIDEO;
          phaseNext = '0;
        end else begin
          phaseNext = phase + PHASE_W'(1);
        end
      end
      VIDEO: begin
        if (!laneDly.active) stateNext = CTRL;
      end
      default: stateNext = CTRL;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state register.
  always_comb begin
    deNext    = 1'b0;
    guardNext = 1'b0;
    ctl1Next  = 2'b00;
    ctl2Next  = 2'b00;
    pixelNext = 24'h0;
    case (stateNext)
      PRE:   ctl1Next = 2'b01;
      GUARD: guardNext = 1'b1;
      VIDEO: begin
        deNext    = 1'b1;
        pixelNext = {laneDly.red, laneDly.green, laneDly.blue};
      end
      default: ;
    endcase
  end

  // Output register; ctl0 carries the delayed syncs in every state.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      de        <= 1'b0;
      guardBand <= 1'b0;
      ctl0      <= 2'b00;
      ctl1      <= 2'b00;
      ctl2      <= 2'b00;
      redOut    <= 8'h0;
      greenOut  <= 8'h0;
      blueOut   <= 8'h0;
    end else begin
      de        <= deNext;
      guardBand <= guardNext;
      ctl0      <= {laneDly.vsync, laneDly.hsync};
      ctl1      <= ctl1Next;
      ctl2      <= ctl2Next;
      {redOut, greenOut, blueOut} <= pixelNext;
    end
  end

  assign hdmiState = state;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: HDMI-mode and DVI-mode instances share one stimulus stream.
// Expected outputs come from a line-level model over the recorded input history.
// Every cycle is compared against that model, plus directed checks on timing boundaries.
module tb_hdmi_period_scheduler;

  localparam int PRE_LEN   = 8;
  localparam int GUARD_LEN = 2;
  localparam int LOOK      = PRE_LEN + GUARD_LEN;
  localparam int LAT       = LOOK + 1;
  localparam int MAXC      = 4096;

  typedef struct packed {
    logic [1:0] state;
    logic       de;
    logic       guard;
    logic [1:0] ctl0;
    logic [1:0] ctl1;
    logic [1:0] ctl2;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       err;
  } snap_t;

  logic       pixelClock = 1'b0;
  logic       resetN;
  logic       hsyncIn, vsyncIn, activeIn, errClear;
  logic [7:0] redIn, greenIn, blueIn;

  logic       deH, guardH, errH, deD, guardD, errD;
  logic [1:0] ctl0H, ctl1H, ctl2H, stateH, ctl0D, ctl1D, ctl2D, stateD;
  logic [7:0] redH, greenH, blueH, redD, greenD, blueD;
  snap_t      obsH, obsD;

  // Input history and bookkeeping.
  bit         actH [MAXC];
  bit         clrH [MAXC];
  bit         rstH [MAXC];
  logic [1:0] syncH [MAXC];
  logic [7:0] rH [MAXC];
  logic [7:0] gH [MAXC];
  logic [7:0] bH [MAXC];
  int         cyc = 0;
  int         epoch = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic       rstDrive = 1'b0;

  always #5 pixelClock = ~pixelClock;

  hdmi_period_scheduler #(.HDMI_MODE(1), .PREAMBLE_LEN(PRE_LEN), .GUARD_LEN(GUARD_LEN)) dutHdmi (
    .pixelClock(pixelClock), .resetN(resetN), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
    .activeIn(activeIn), .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .errClear(errClear), .de(deH), .ctl0(ctl0H), .ctl1(ctl1H), .ctl2(ctl2H),
    .guardBand(guardH), .redOut(redH), .greenOut(greenH), .blueOut(blueH),
    .hdmiState(stateH), .shortBlankErr(errH));

  hdmi_period_scheduler #(.HDMI_MODE(0), .PREAMBLE_LEN(PRE_LEN), .GUARD_LEN(GUARD_LEN)) dutDvi (
    .pixelClock(pixelClock), .resetN(resetN), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
    .activeIn(activeIn), .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .errClear(errClear), .de(deD), .ctl0(ctl0D), .ctl1(ctl1D), .ctl2(ctl2D),
    .guardBand(guardD), .redOut(redD), .greenOut(greenD), .blueOut(blueD),
    .hdmiState(stateD), .shortBlankErr(errD));

  assign obsH = {stateH, deH, guardH, ctl0H, ctl1H, ctl2H, redH, greenH, blueH, errH};
  assign obsD = {stateD, deD, guardD, ctl0D, ctl1D, ctl2D, redD, greenD, blueD, errD};

  // Rising edge of the recorded activeIn; the cycle right after reset counts as preceded by blanking.
  function automatic bit isEdge(input int n);
    return actH[n] && (n == epoch || !actH[n-1]);
  endfunction

  // A line earns a preamble when at least LOOK+4 blank cycles precede its first active cycle.
  function automatic bit isQualified(input bit mode, input int n);
    int run;
    run = 0;
    if (!mode || !isEdge(n)) return 1'b0;
    for (int s = n - 1; s >= epoch; s--) begin
      if (actH[s]) return (run >= LOOK + 4);
      run++;
    end
    return 1'b1;
  endfunction

  // Expected output snapshot for output cycle t.
  function automatic snap_t expOut(input bit mode, input int t);
    snap_t e;
    int    s;
    int    lastSet;
    int    lastClr;
    e = '0;
    if (!rstH[t]) return e;
    s = t - LAT;
    if (s >= epoch) e.ctl0 = syncH[s];
    for (int k = 1; k <= LOOK; k++)
      if (t - k >= epoch && isQualified(mode, t - k)) e.state = (k <= PRE_LEN) ? 2'd1 : 2'd2;
    if (e.state == 2'd0 && s >= epoch && actH[s]) e.state = 2'd3;
    e.de    = (e.state == 2'd3);
    e.guard = (e.state == 2'd2);
    e.ctl1  = (e.state == 2'd1) ? 2'b01 : 2'b00;
    if (e.de) begin
      e.red   = rH[s];
      e.green = gH[s];
      e.blue  = bH[s];
    end
    if (mode) begin
      lastSet = -1;
      lastClr = -1;
      for (int u = epoch; u < t; u++) begin
        if (isEdge(u) && !isQualified(1'b1, u)) lastSet = u;
        if (clrH[u]) lastClr = u;
      end
      e.err = (lastSet >= 0) && (lastClr <= lastSet);
    end
    return e;
  endfunction

  // Drive one input cycle just after the rising edge and park at the falling edge for sampling.
  task automatic step(input logic a, input logic [1:0] sync, input logic clr);
    @(posedge pixelClock);
    #1;
    cyc++;
    if (!resetN && rstDrive) epoch = cyc;
    resetN   = rstDrive;
    activeIn = a;
    {vsyncIn, hsyncIn} = sync;
    redIn    = 8'($urandom_range(0, 255));
    greenIn  = 8'($urandom_range(0, 255));
    blueIn   = 8'($urandom_range(0, 255));
    errClear = clr;
    actH[cyc] = a;  syncH[cyc] = sync; clrH[cyc] = clr; rstH[cyc] = rstDrive;
    rH[cyc] = redIn; gH[cyc] = greenIn; bH[cyc] = blueIn;
    @(negedge pixelClock);
  endtask

  task automatic test_reset;
    snap_t eH, eD;
    #2 resetN = 1'b0;
    #1;
    vectors += 2;
    if (obsH !== '0) begin miscompares++; $display("FAIL reset_async.hdmi got=%h want=0", obsH); end
    if (obsD !== '0) begin miscompares++; $display("FAIL reset_async.dvi got=%h want=0", obsD); end
    for (int i = 0; i < 9; i++) begin
      if (i == 3) rstDrive = 1'b1;
      step(1'b0, 2'b00, 1'b0);
      eH = expOut(1'b1, cyc); eD = expOut(1'b0, cyc);
      vectors += 2;
      if (obsH !== eH) begin miscompares++; $display("FAIL reset_idle.hdmi t=%0d got=%h want=%h", cyc, obsH, eH); end
      if (obsD !== eD) begin miscompares++; $display("FAIL reset_idle.dvi t=%0d got=%h want=%h", cyc, obsD, eD); end
    end
  endtask

  // 20 blank cycles, 4 active at N, syncs toggling throughout.
  task automatic test_long_blank;
    snap_t eH, eD;
    int n, k;
    logic [1:0] want;
    n = cyc + 21;
    for (int i = 0; i < 40; i++) begin
      step(i >= 20 && i < 24, 2'(i), 1'b0);
      eH = expOut(1'b1, cyc); eD = expOut(1'b0, cyc);
      k = cyc - n;
      want = 2'd0;
      if (k >= 1 && k <= PRE_LEN) want = 2'd1;
      else if (k > PRE_LEN && k <= LOOK) want = 2'd2;
      else if (k > LOOK && k <= LOOK + 4) want = 2'd3;
      vectors += 4;
      if (obsH !== eH) begin miscompares++; $display("FAIL long_blank.hdmi k=%0d got=%h want=%h", k, obsH, eH); end
      if (obsD !== eD) begin miscompares++; $display("FAIL long_blank.dvi k=%0d got=%h want=%h", k, obsD, eD); end
      if (stateH !== want) begin miscompares++; $display("FAIL long_blank_state.hdmi k=%0d got=%0d want=%0d", k, stateH, want); end
      if (stateD !== ((want == 2'd3) ? 2'd3 : 2'd0)) begin
        miscompares++; $display("FAIL long_blank_state.dvi k=%0d got=%0d", k, stateD);
      end
    end
  endtask

  // Qualified one-cycle line, 13 blank cycles, then a short-blank line at N; errClear later.
  task automatic test_short_blank;
    snap_t eH, eD;
    int n, k;
    logic a, clr;
    n = cyc + 35;
    for (int i = 0; i < 57; i++) begin
      a   = (i == 20) || (i >= 34 && i <= 36);
      clr = (i == 53);
      step(a, 2'($urandom_range(0, 3)), clr);
      eH = expOut(1'b1, cyc); eD = expOut(1'b0, cyc);
      k = cyc - n;
      vectors += 2;
      if (obsH !== eH) begin miscompares++; $display("FAIL short_blank.hdmi k=%0d got=%h want=%h", k, obsH, eH); end
      if (obsD !== eD) begin miscompares++; $display("FAIL short_blank.dvi k=%0d got=%h want=%h", k, obsD, eD); end
      if (k >= 1 && k <= LOOK + 1) begin
        vectors++;
        if (stateH == 2'd1 || stateH == 2'd2) begin
          miscompares++; $display("FAIL short_blank_nopre k=%0d got=%0d want=0or3", k, stateH);
        end
      end
      if (k == 1) begin
        vectors++;
        if (errH !== 1'b1) begin miscompares++; $display("FAIL short_blank_err_set got=%b want=1", errH); end
      end
      if (k == LOOK || k == LOOK + 1) begin
        vectors++;
        if (deH !== (k == LOOK + 1)) begin miscompares++; $display("FAIL short_blank_de k=%0d got=%b", k, deH); end
      end
      if (i == 54) begin
        vectors++;
        if (errH !== 1'b0) begin miscompares++; $display("FAIL short_blank_err_clear got=%b want=0", errH); end
      end
    end
  endtask

  // Single-cycle active pulse after long blanking.
  task automatic test_single_pulse;
    snap_t eH, eD;
    int preCnt, guardCnt, deCntH, deCntD;
    preCnt = 0; guardCnt = 0; deCntH = 0; deCntD = 0;
    for (int i = 0; i < 40; i++) begin
      step(i == 20, 2'($urandom_range(0, 3)), 1'b0);
      eH = expOut(1'b1, cyc); eD = expOut(1'b0, cyc);
      vectors += 2;
      if (obsH !== eH) begin miscompares++; $display("FAIL single_pulse.hdmi t=%0d got=%h want=%h", cyc, obsH, eH); end
      if (obsD !== eD) begin miscompares++; $display("FAIL single_pulse.dvi t=%0d got=%h want=%h", cyc, obsD, eD); end
      preCnt   += (stateH == 2'd1);
      guardCnt += guardH;
      deCntH   += deH;
      deCntD   += deD;
    end
    vectors += 4;
    if (preCnt !== PRE_LEN) begin miscompares++; $display("FAIL single_pulse_pre got=%0d want=%0d", preCnt, PRE_LEN); end
    if (guardCnt !== GUARD_LEN) begin miscompares++; $display("FAIL single_pulse_guard got=%0d want=%0d", guardCnt, GUARD_LEN); end
    if (deCntH !== 1) begin miscompares++; $display("FAIL single_pulse_de.hdmi got=%0d want=1", deCntH); end
    if (deCntD !== 1) begin miscompares++; $display("FAIL single_pulse_de.dvi got=%0d want=1", deCntD); end
  endtask

  // Reset pulsed during GUARD, then a full line afterwards.
  task automatic test_reset_in_guard;
    snap_t eH, eD;
    int preCnt, guardCnt, deCnt;
    for (int i = 0; i < 30; i++) begin
      step(i >= 20 && i < 24, 2'($urandom_range(0, 3)), 1'b0);
      eH = expOut(1'b1, cyc);
      vectors++;
      if (obsH !== eH) begin miscompares++; $display("FAIL guard_reset_pre.hdmi t=%0d got=%h want=%h", cyc, obsH, eH); end
    end
    vectors++;
    if (stateH !== 2'd2 || guardH !== 1'b1) begin
      miscompares++; $display("FAIL guard_reset_in_guard got=%0d/%b want=2/1", stateH, guardH);
    end
    rstDrive = 1'b0;
    resetN   = 1'b0;
    #1;
    vectors += 2;
    if (obsH !== '0) begin miscompares++; $display("FAIL guard_reset_drop.hdmi got=%h want=0", obsH); end
    if (obsD !== '0) begin miscompares++; $display("FAIL guard_reset_drop.dvi got=%h want=0", obsD); end
    preCnt = 0; guardCnt = 0; deCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) rstDrive = 1'b1;
      step(i >= 22 && i < 25, 2'($urandom_range(0, 3)), 1'b0);
      eH = expOut(1'b1, cyc); eD = expOut(1'b0, cyc);
      vectors += 2;
      if (obsH !== eH) begin miscompares++; $display("FAIL guard_reset_after.hdmi t=%0d got=%h want=%h", cyc, obsH, eH); end
      if (obsD !== eD) begin miscompares++; $display("FAIL guard_reset_after.dvi t=%0d got=%h want=%h", cyc, obsD, eD); end
      preCnt   += (stateH == 2'd1);
      guardCnt += guardH;
      deCnt    += deH;
    end
    vectors += 3;
    if (preCnt !== PRE_LEN) begin miscompares++; $display("FAIL guard_reset_pre_cnt got=%0d want=%0d", preCnt, PRE_LEN); end
    if (guardCnt !== GUARD_LEN) begin miscompares++; $display("FAIL guard_reset_guard_cnt got=%0d want=%0d", guardCnt, GUARD_LEN); end
    if (deCnt !== 3) begin miscompares++; $display("FAIL guard_reset_de_cnt got=%0d want=3", deCnt); end
  endtask

  // Random lines: blanking around the qualification threshold, random active lengths, syncs and clears.
  task automatic test_random;
    snap_t eH, eD;
    bit    actQ [$];
    int    blanks [4] = '{13, 14, 15, 12};
    int    nb;
    for (int l = 0; l < 44; l++) begin
      nb = (l < 4) ? blanks[l] : int'($urandom_range(1, 24));
      repeat (nb) actQ.push_back(1'b0);
      repeat ($urandom_range(1, 6)) actQ.push_back(1'b1);
    end
    repeat (16) actQ.push_back(1'b0);
    foreach (actQ[i]) begin
      if (cyc + 1 >= MAXC) break;
      step(actQ[i], 2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      eH = expOut(1'b1, cyc); eD = expOut(1'b0, cyc);
      vectors += 2;
      if (obsH !== eH) begin miscompares++; $display("FAIL random.hdmi t=%0d got=%h want=%h", cyc, obsH, eH); end
      if (obsD !== eD) begin miscompares++; $display("FAIL random.dvi t=%0d got=%h want=%h", cyc, obsD, eD); end
    end
  endtask

  initial begin
    resetN   = 1'b1;
    activeIn = 1'b0; hsyncIn = 1'b0; vsyncIn = 1'b0; errClear = 1'b0;
    redIn = 8'h0; greenIn = 8'h0; blueIn = 8'h0;
    test_reset();
    test_long_blank();
    test_short_blank();
    test_single_pulse();
    test_reset_in_guard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
